// File: rtl/alu_seq_pkg.sv
// Shared types and opcode constants for the ALU sequencing controller.
// Optional writeback stage is selected by the ALU_SEQ_WRITEBACK_EN macro.
package alu_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DECODE  = 3'd1,
        ST_EXEC    = 3'd2,
        ST_CAPT    = 3'd3,
        ST_WB      = 3'd4,
        ST_RELEASE = 3'd5
    } alu_seq_state_t;

    localparam logic [3:0] OP_LOADA = 4'b1111;
    localparam logic [3:0] OP_LOADB = 4'b1101;
    localparam logic [3:0] OP_SWAP  = 4'b1110;

    // Register-file ops finish in DECODE; everything else goes through the ALU.
    function automatic logic is_reg_op(input logic [3:0] op);
        return (op == OP_LOADA) || (op == OP_LOADB) || (op == OP_SWAP);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop synchronizer, stability counter and a one-cycle
// press pulse on each accepted rising edge. Reusable for any board button.
module btn_debounce #(
    parameter int DB_CYCLES = 50000,
    parameter int DB_W      = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic level,
    output logic press
);

    localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DB_CYCLES - 1);

    logic            sync_1;
    logic            sync_2;
    logic [DB_W-1:0] cnt;

    // The counter only runs while the synchronized input disagrees with the
    // accepted level; any return to the old level restarts it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
            cnt    <= '0;
            level  <= 1'b0;
            press  <= 1'b0;
        end else begin
            sync_1 <= btn_raw;
            sync_2 <= sync_1;
            press  <= 1'b0;
            if (sync_2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt   <= '0;
                level <= sync_2;
                press <= sync_2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_seq_ctrl.sv
// One-operation-per-press sequencer for the ALU/register datapath.
// Define ALU_SEQ_WRITEBACK_EN to write ALU results back into register A.
module alu_seq_ctrl
    import alu_seq_pkg::*;
#(
    parameter int DB_CYCLES   = 50000,
    parameter int DB_W        = 16,
    parameter int EXEC_CYCLES = 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           btn_raw,
    input  logic [3:0]     op,
    input  logic [7:0]     alu_y,
    output logic           load_a,
    output logic           load_b,
    output logic           swap,
    output logic           wb_sel,
    output logic [3:0]     op_q,
    output logic [7:0]     y_reg,
    output logic           busy,
    output logic           done,
    output alu_seq_state_t dbg_state
);

    localparam logic [3:0] EXEC_LOAD = 4'(EXEC_CYCLES - 1);

    // Handshake: press is a one-cycle pulse accepted only in IDLE; strobes
    // and done are single-cycle pulses with no backpressure from the datapath.
    logic           db_level;
    logic           press;
    logic [3:0]     exec_cnt;
    alu_seq_state_t state;

    btn_debounce #(
        .DB_CYCLES (DB_CYCLES),
        .DB_W      (DB_W)
    ) u_btn_debounce (
        .clk     (clk),
        .reset   (reset),
        .btn_raw (btn_raw),
        .level   (db_level),
        .press   (press)
    );

`ifdef ALU_SEQ_WRITEBACK_EN
    logic wb_sel_q;
    assign wb_sel = wb_sel_q;
`else
    assign wb_sel = 1'b0;
`endif

    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= ST_IDLE;
            exec_cnt <= '0;
            op_q     <= '0;
            y_reg    <= '0;
            load_a   <= 1'b0;
            load_b   <= 1'b0;
            swap     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
`ifdef ALU_SEQ_WRITEBACK_EN
            wb_sel_q <= 1'b0;
`endif
        end else begin
            load_a <= 1'b0;
            load_b <= 1'b0;
            swap   <= 1'b0;
            done   <= 1'b0;
`ifdef ALU_SEQ_WRITEBACK_EN
            wb_sel_q <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    if (press) begin
                        op_q  <= op;
                        busy  <= 1'b1;
                        state <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    if (is_reg_op(op_q)) begin
                        load_a <= (op_q == OP_LOADA);
                        load_b <= (op_q == OP_LOADB);
                        swap   <= (op_q == OP_SWAP);
                        done   <= 1'b1;
                        state  <= ST_RELEASE;
                    end else begin
                        exec_cnt <= EXEC_LOAD;
                        state    <= ST_EXEC;
                    end
                end
                // Capture lands on the edge that enters CAPT, so y_reg is
                // valid in the first CAPT cycle.
                ST_EXEC: begin
                    if (exec_cnt == 4'd0) begin
                        y_reg <= alu_y;
                        state <= ST_CAPT;
`ifndef ALU_SEQ_WRITEBACK_EN
                        done  <= 1'b1;
`endif
                    end else begin
                        exec_cnt <= exec_cnt - 4'd1;
                    end
                end
                ST_CAPT: begin
`ifdef ALU_SEQ_WRITEBACK_EN
                    wb_sel_q <= 1'b1;
                    load_a   <= 1'b1;
                    done     <= 1'b1;
                    state    <= ST_WB;
`else
                    busy  <= 1'b0;
                    state <= ST_RELEASE;
`endif
                end
`ifdef ALU_SEQ_WRITEBACK_EN
                ST_WB: begin
                    busy  <= 1'b0;
                    state <= ST_RELEASE;
                end
`endif
                ST_RELEASE: begin
                    busy <= 1'b0;
                    if (!db_level) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl with short debounce and a 3-cycle ALU.
// Expectations come from cycle formulas relative to the button edge.
module tb_alu_seq_ctrl;
    import alu_seq_pkg::*;

    localparam int DB   = 4;
    localparam int EXEC = 3;
`ifdef ALU_SEQ_WRITEBACK_EN
    localparam int WB = 1;
`else
    localparam int WB = 0;
`endif

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           btn_raw = 1'b0;
    logic [3:0]     op = 4'd0;
    logic [7:0]     alu_y = 8'd0;
    logic           load_a, load_b, swap, wb_sel, busy, done;
    logic [3:0]     op_q;
    logic [7:0]     y_reg;
    alu_seq_state_t dbg_state;

    int checks = 0;
    int failures = 0;
    logic [7:0] y_model = 8'd0;
    logic [3:0] opq_model = 4'd0;

    alu_seq_ctrl #(.DB_CYCLES(DB), .DB_W(4), .EXEC_CYCLES(EXEC)) dut (
        .clk(clk), .reset(reset), .btn_raw(btn_raw), .op(op), .alu_y(alu_y),
        .load_a(load_a), .load_b(load_b), .swap(swap), .wb_sel(wb_sel),
        .op_q(op_q), .y_reg(y_reg), .busy(busy), .done(done), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        step();
        step();
        checks++;
        if ({load_a, load_b, swap, wb_sel, busy, done, op_q, y_reg} !== 18'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%h want=0", {load_a, load_b, swap, wb_sel, busy, done, op_q, y_reg});
        end
        checks++;
        if (dbg_state !== ST_IDLE) begin
            failures++;
            $display("FAIL reset_state got=%0d want=%0d", dbg_state, ST_IDLE);
        end
        reset = 1'b1;
        step();
    endtask

    // Press the button at k=0 with opcode o, hold it for hold cycles, and check
    // every output every cycle against the timeline derived from the press.
    task automatic test_op(input logic [3:0] o, input logic [7:0] y, input int hold);
        int n, cap, done_k, last_k;
        logic is_reg, e_la, e_lb, e_sw, e_wb, e_done, e_busy;
        logic [7:0] e_y;
        logic [3:0] e_opq;
        n = 2 + DB;
        is_reg = (o == 4'hF) || (o == 4'hD) || (o == 4'hE);
        cap = n + 2 + EXEC;
        done_k = is_reg ? n + 2 : cap + WB;
        last_k = done_k + 3;
        op = o;
        alu_y = y;
        btn_raw = 1'b1;
        for (int k = 1; k <= last_k; k++) begin
            step();
            if (k == hold) btn_raw = 1'b0;
            e_la   = (k == done_k) && ((is_reg && o == 4'hF) || (!is_reg && WB == 1));
            e_lb   = (k == done_k) && is_reg && (o == 4'hD);
            e_sw   = (k == done_k) && is_reg && (o == 4'hE);
            e_wb   = (k == done_k) && !is_reg && (WB == 1);
            e_done = (k == done_k);
            e_busy = (k > n) && (k <= done_k);
            e_y    = (!is_reg && k >= cap) ? y : y_model;
            e_opq  = (k > n) ? o : opq_model;
            checks++;
            if ({load_a, load_b, swap, wb_sel, done, busy} !== {e_la, e_lb, e_sw, e_wb, e_done, e_busy}) begin
                failures++;
                $display("FAIL op%h_ctrl k=%0d got la/lb/sw/wb/done/busy=%b want=%b", o, k,
                         {load_a, load_b, swap, wb_sel, done, busy}, {e_la, e_lb, e_sw, e_wb, e_done, e_busy});
            end
            checks++;
            if (y_reg !== e_y || op_q !== e_opq) begin
                failures++;
                $display("FAIL op%h_regs k=%0d got y=%h opq=%h want y=%h opq=%h", o, k, y_reg, op_q, e_y, e_opq);
            end
        end
        opq_model = o;
        if (!is_reg) y_model = y;
        btn_raw = 1'b0;
        for (int k = 0; k < DB + 4; k++) step();
        checks++;
        if (dbg_state !== ST_IDLE) begin
            failures++;
            $display("FAIL op%h_return got state=%0d want=%0d", o, dbg_state, ST_IDLE);
        end
    endtask

    task automatic test_register_ops();
        test_op(4'hF, 8'h11, 1000);
        test_op(4'hD, 8'h22, DB + 5);
        test_op(4'hE, 8'h33, DB + 8);
    endtask

    task automatic test_alu_op();
        test_op(4'h2, 8'h5A, 1000);
    endtask

    task automatic test_bounce();
        int strobes = 0;
        for (int k = 0; k < 20; k++) begin
            if (k % 2 == 0) btn_raw = ~btn_raw;
            step();
            strobes += int'(load_a) + int'(load_b) + int'(swap) + int'(done) + int'(busy);
        end
        btn_raw = 1'b0;
        for (int k = 0; k < DB + 6; k++) begin
            step();
            strobes += int'(load_a) + int'(load_b) + int'(swap) + int'(done) + int'(busy);
        end
        checks++;
        if (strobes !== 0 || dbg_state !== ST_IDLE) begin
            failures++;
            $display("FAIL bounce got strobes=%0d state=%0d want 0 and IDLE", strobes, dbg_state);
        end
    endtask

    task automatic test_hold_swap();
        int swaps = 0;
        int others = 0;
        op = 4'hE;
        btn_raw = 1'b1;
        for (int k = 0; k < 1000; k++) begin
            step();
            swaps += int'(swap);
            others += int'(load_a) + int'(load_b);
        end
        checks++;
        if (swaps !== 1 || others !== 0) begin
            failures++;
            $display("FAIL hold_swap got swaps=%0d others=%0d want 1 and 0", swaps, others);
        end
        checks++;
        if (dbg_state !== ST_RELEASE || busy !== 1'b0) begin
            failures++;
            $display("FAIL hold_state got state=%0d busy=%b want %0d and 0", dbg_state, busy, ST_RELEASE);
        end
        btn_raw = 1'b0;
        for (int k = 0; k < DB + 4; k++) step();
        checks++;
        if (dbg_state !== ST_IDLE) begin
            failures++;
            $display("FAIL hold_release got state=%0d want=%0d", dbg_state, ST_IDLE);
        end
        opq_model = 4'hE;
    endtask

    task automatic test_op_change();
        int la = 0;
        int lb = 0;
        int sw = 0;
        op = 4'h2;
        alu_y = 8'hC3;
        btn_raw = 1'b1;
        for (int k = 1; k <= 2 + DB + EXEC + 8; k++) begin
            step();
            if (k == 2 + DB + 3) op = 4'hD;
            if (k == 2 + DB + 4) op = 4'hF;
            la += int'(load_a);
            lb += int'(load_b);
            sw += int'(swap);
        end
        checks++;
        if (op_q !== 4'h2 || y_reg !== 8'hC3) begin
            failures++;
            $display("FAIL op_change_regs got opq=%h y=%h want 2 and c3", op_q, y_reg);
        end
        checks++;
        if (lb !== 0 || sw !== 0 || la !== WB) begin
            failures++;
            $display("FAIL op_change_strobes got la=%0d lb=%0d sw=%0d want %0d 0 0", la, lb, sw, WB);
        end
        btn_raw = 1'b0;
        for (int k = 0; k < DB + 4; k++) step();
        opq_model = 4'h2;
        y_model = 8'hC3;
    endtask

    task automatic test_reset_in_exec();
        int dones = 0;
        op = 4'h7;
        alu_y = 8'h99;
        btn_raw = 1'b1;
        for (int k = 1; k <= 2 + DB + 3; k++) step();
        checks++;
        if (dbg_state !== ST_EXEC) begin
            failures++;
            $display("FAIL reset_exec_pre got state=%0d want=%0d", dbg_state, ST_EXEC);
        end
        reset = 1'b0;
        btn_raw = 1'b0;
        step();
        checks++;
        if ({load_a, load_b, swap, wb_sel, busy, done, op_q, y_reg} !== 18'd0 || dbg_state !== ST_IDLE) begin
            failures++;
            $display("FAIL reset_exec got outs=%h state=%0d want 0 and IDLE",
                     {load_a, load_b, swap, wb_sel, busy, done, op_q, y_reg}, dbg_state);
        end
        reset = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step();
            dones += int'(done) + int'(load_a) + int'(busy);
        end
        checks++;
        if (dones !== 0) begin
            failures++;
            $display("FAIL reset_exec_after got pulses=%0d want 0", dones);
        end
        y_model = 8'd0;
        opq_model = 4'd0;
    endtask

    task automatic test_random();
        logic [3:0] o;
        for (int i = 0; i < 8; i++) begin
            case ($urandom_range(0, 3))
                0: o = 4'hF;
                1: o = 4'hD;
                2: o = 4'hE;
                default: begin
                    o = 4'($urandom_range(0, 12));
                end
            endcase
            test_op(o, 8'($urandom_range(0, 255)), $urandom_range(2 + DB + 2 + EXEC + WB, 40));
        end
    endtask

    task automatic test_back_to_back();
        test_op(4'h3, 8'hA5, 2 + DB + 2 + EXEC + WB);
        test_op(4'hF, 8'h00, 2 + DB + 2);
    endtask

    initial begin
        test_reset();
        test_register_ops();
        test_alu_op();
        test_bounce();
        test_hold_swap();
        test_op_change();
        test_reset_in_exec();
        test_random();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
